// File: rtl/uram_partition_drain_pkg.sv
// Shared types for the partition-drain read controller.
package phj_pkg;

    typedef enum logic [1:0] {
        DRN_IDLE,
        DRN_RUN,
        DRN_DRAIN,
        DRN_DONE
    } drain_state_t;

endpackage : phj_pkg

// File: rtl/uram_partition_drain.sv
// Read-side controller for the URAM partition buffer: streams `length` words
// starting at `base_addr` (wrapping) as a valid/ready stream with last.
// The URAM output register is the stream data register; ram_out_ready freezes
// it under backpressure so m_data needs no local copy.
import phj_pkg::*;

module uram_partition_drain #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 3,
    parameter int CNT_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic                  ram_out_ready,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready
);

    drain_state_t         state;
    drain_state_t         state_next;
    logic [CNT_WIDTH-1:0] remaining;
    logic                 advance;
    logic                 issue;

    assign m_data = ram_rdata;

    // Next-state, handshake qualifiers and status outputs.
    always_comb begin
        advance       = !m_valid || m_ready;
        ram_out_ready = advance;
        issue         = advance && (state == DRN_RUN) && (remaining != '0);
        state_next    = state;
        busy          = (state == DRN_RUN) || (state == DRN_DRAIN);
        done          = (state == DRN_DONE);
        case (state)
            DRN_IDLE: begin
                if (start) begin
                    state_next = (length == '0) ? DRN_DONE : DRN_RUN;
                end
            end
            DRN_RUN: begin
                if (issue && (remaining == CNT_WIDTH'(1))) begin
                    state_next = DRN_DRAIN;
                end
            end
            DRN_DRAIN: begin
                if (m_valid && m_ready && m_last) begin
                    state_next = DRN_DONE;
                end
            end
            DRN_DONE: begin
                state_next = DRN_IDLE;
            end
            default: begin
                state_next = DRN_IDLE;
            end
        endcase
    end

    // State register, read address / word counter and stream valid/last.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= DRN_IDLE;
            ram_raddr <= '0;
            remaining <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
        end else begin
            state <= state_next;
            if ((state == DRN_IDLE) && start) begin
                ram_raddr <= base_addr;
                remaining <= length;
            end
            // An issue edge is also the edge where the URAM register captures
            // the word, so valid/last move in lockstep with the data.
            if (issue) begin
                ram_raddr <= ram_raddr + 1'b1;
                remaining <= remaining - 1'b1;
                m_valid   <= 1'b1;
                m_last    <= (remaining == CNT_WIDTH'(1));
            end else if (advance) begin
                m_valid   <= 1'b0;
                m_last    <= 1'b0;
            end
        end
    end

endmodule : uram_partition_drain
